// File: rtl/player_ctrl_if.sv
// Bundle of the player controller's frame/button/position inputs and
// sprite-sweep/VGA outputs; master is the controller side.
interface player_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic [6:0] y_cur;
  logic       add_x;
  logic [1:0] add_y;
  logic       y_pos_mod;
  logic       y_neg_mod;
  logic       plot;
  logic [2:0] colour;
  logic       busy;

  modport master (
    input  frame_tick, btn_up, btn_down, y_cur,
    output add_x, add_y, y_pos_mod, y_neg_mod, plot, colour, busy
  );

  modport slave (
    output frame_tick, btn_up, btn_down, y_cur,
    input  add_x, add_y, y_pos_mod, y_neg_mod, plot, colour, busy
  );
endinterface

// File: rtl/player_ctrl.sv
// Player control FSM: per-frame button sampling, bounds check, and the
// erase / move / redraw sequence over the 2x4 ship sprite.
module player_ctrl #(
  parameter logic [2:0] SHIP_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [6:0] Y_MAX       = 7'd116
) (
  input  logic           clk,
  input  logic           reset_n,
  player_ctrl_if.master  bus
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERASE, S_MOVE, S_DRAW} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rst_q;
  logic       up_meta_q, up_s_q, down_meta_q, down_s_q;

  logic       up_legal, down_legal;
  logic       add_x_o;
  logic [1:0] add_y_o;
  logic       y_pos_mod_o, y_neg_mod_o, plot_o, busy_o;
  logic [2:0] colour_o;

  // rst_q marks the cycle(s) that follow a sampled reset: INIT is loaded but
  // held silent, so INIT's first pixel appears only after reset_n is seen high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      dir_q       <= DIR_NONE;
      rst_q       <= 1'b1;
      up_meta_q   <= 1'b0;
      up_s_q      <= 1'b0;
      down_meta_q <= 1'b0;
      down_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      rst_q       <= 1'b0;
      up_meta_q   <= bus.btn_up;
      up_s_q      <= up_meta_q;
      down_meta_q <= bus.btn_down;
      down_s_q    <= down_meta_q;
    end
  end

  always_comb begin
    up_legal   = up_s_q & ~down_s_q & (bus.y_cur != '0);
    down_legal = down_s_q & ~up_s_q & (bus.y_cur < Y_MAX);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (!rst_q) begin
      unique case (state_q)
        S_INIT: begin
          if (cnt_q == 3'd7) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_IDLE: begin
          if (bus.frame_tick && (up_legal || down_legal)) begin
            state_d = S_ERASE;
            cnt_d   = '0;
            dir_d   = up_legal ? DIR_UP : DIR_DOWN;
          end
        end
        S_ERASE: begin
          if (cnt_q == 3'd7) begin
            state_d = S_MOVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_MOVE: begin
          state_d = S_DRAW;
          cnt_d   = '0;
        end
        S_DRAW: begin
          if (cnt_q == 3'd7) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dir_d   = DIR_NONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = S_INIT;
          cnt_d   = '0;
          dir_d   = DIR_NONE;
        end
      endcase
    end
  end

  always_comb begin
    add_x_o     = cnt_q[0];
    add_y_o     = cnt_q[2:1];
    y_pos_mod_o = 1'b0;
    y_neg_mod_o = 1'b0;
    plot_o      = 1'b0;
    colour_o    = BG_COLOUR;
    busy_o      = (state_q != S_IDLE);
    if (!rst_q) begin
      unique case (state_q)
        S_INIT, S_DRAW: begin
          plot_o   = 1'b1;
          colour_o = SHIP_COLOUR;
        end
        S_ERASE: plot_o = 1'b1;
        S_MOVE: begin
          y_pos_mod_o = (dir_q == DIR_UP);
          y_neg_mod_o = (dir_q == DIR_DOWN);
        end
        default: ;
      endcase
    end
  end

  assign bus.add_x     = add_x_o;
  assign bus.add_y     = add_y_o;
  assign bus.y_pos_mod = y_pos_mod_o;
  assign bus.y_neg_mod = y_neg_mod_o;
  assign bus.plot      = plot_o;
  assign bus.colour    = colour_o;
  assign bus.busy      = busy_o;

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Control FSM directly upstream of the player datapath. It samples the up/down buttons once per frame tick and bounds-checks the ship's current top row. For a legal move it sequences erase, move and redraw: it sweeps the 2x4 sprite pixel offsets (add_x/add_y), pulses the one-cycle move strobes, and drives plot/colour to the VGA adapter.

## Interface
Parameters:
- SHIP_COLOUR, 3'b010, colour for ship pixels in INIT/DRAW
- BG_COLOUR, 3'b000, colour for erased pixels in ERASE
- Y_MAX, 7'd116, largest legal ship top row (120-row screen, 4-row sprite)

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- frame_tick  input  1  one-cycle pulse per frame (60 Hz)
- btn_up  input  1  raw asynchronous level, move up
- btn_down  input  1  raw asynchronous level, move down
- y_cur  input  7  ship top row currently held by the datapath
- add_x  output  1  sprite column offset
- add_y  output  2  sprite row offset
- y_pos_mod  output  1  one-cycle strobe; datapath decrements y (up)
- y_neg_mod  output  1  one-cycle strobe; datapath increments y (down)
- plot  output  1  VGA write enable
- colour  output  3  VGA pixel colour
- busy  output  1  high in every state except IDLE

## Operation
- Reset is synchronous, active-low, on clock clk and reset_n. The reset cycle loads state=INIT, cnt=0 and dir=NONE.
- Button input: btn_up and btn_down each pass through a 2-flop synchroniser, giving up_s and down_s.
- Pixel counter cnt is 3 bits. add_x=cnt[0] and add_y=cnt[2:1], so x varies fastest: (0,0),(1,0),(0,1),(1,1) … (1,3).
- States:
  - INIT: plot=1, colour=SHIP_COLOUR, cnt increments. At cnt=7 go to IDLE and clear cnt.
  - IDLE: plot=0, busy=0.
    - On frame_tick: up_legal = up_s & !down_s & (y_cur != 0); down_legal = down_s & !up_s & (y_cur < Y_MAX).
    - If either is legal, latch dir and go to ERASE with cnt=0. Otherwise stay in IDLE.
  - ERASE: plot=1, colour=BG_COLOUR, 8 cycles (cnt 0..7), then go to MOVE.
  - MOVE: exactly one cycle, plot=0. y_pos_mod=1 if dir=UP, y_neg_mod=1 if dir=DOWN. Go to DRAW with cnt=0.
  - DRAW: plot=1, colour=SHIP_COLOUR, 8 cycles, then go to IDLE and set dir=NONE.
- Outputs are Moore, decoded from the registered state/cnt/dir. There are no combinational paths from any input to any output.
- frame_tick outside IDLE is ignored; it is neither queued nor counted.
- If both buttons are pressed, or the move hits a boundary (up at y_cur=0, down at y_cur>=Y_MAX), there is no move and no erase/redraw.
- y_cur is sampled only in IDLE on the tick cycle. y_pos_mod and y_neg_mod are never high at the same time, and each is never high outside MOVE.
- Reset mid-operation (any state): the next state is INIT with cnt=0 and dir=NONE. Strobes drop immediately on the reset cycle's clock edge.

## Timing
- Output values during and immediately after reset: add_x=0, add_y=0, y_pos_mod=0, y_neg_mod=0, plot=0, colour=BG_COLOUR, busy=1.
- The first cycle after reset_n rises is INIT cnt=0, with plot=1. INIT occupies 8 cycles, then IDLE.
- Button-to-sampling latency: 2 cycles through the synchroniser. A press must be stable at least 2 cycles before frame_tick to be honoured.
- A tick accepted at edge T gives:
  - ERASE on cycles T+1..T+8
  - MOVE on T+9; the datapath y updates at the end of T+9
  - DRAW on T+10..T+17
  - IDLE from T+18
- Total busy time is 17 cycles per move. A new tick is accepted at the earliest on cycle T+18.
- DRAW pixels use the already-updated datapath y, because the strobe lands one edge before the first DRAW cycle.

## Test plan
- Reset then release: the 8 INIT cycles emit plot=1, colour=010 and (add_x,add_y) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(0,3),(1,3). After that busy=0 and plot=0.
- btn_down held, y_cur=10, frame_tick pulse -> 8 plot cycles with colour=000, then y_neg_mod=1 for exactly 1 cycle, then 8 plot cycles with colour=010. busy is high for 17 cycles.
- btn_up held with y_cur=0, and separately btn_down held with y_cur=116, each followed by a tick -> no strobe, plot stays 0, busy stays 0.
- btn_up and btn_down both held, y_cur=50, tick -> no activity.
- Second frame_tick 5 cycles after an accepted tick -> ignored: exactly one y_pos_mod pulse and exactly 16 plot cycles in total.
- reset_n low during DRAW cnt=3 -> plot=0 and strobes 0 on the next cycle. After release, a full 8-cycle INIT occurs with no ERASE.
